// File: rtl/pcx_spc_credit_ctl.sv
// Per-destination PCX queue credit tracker with quiesce/drain handshake.
// Counts requests minus grants per destination and exposes issue permission.
module pcx_spc_credit_ctl #(
  parameter int NDEST  = 5,
  parameter int QDEPTH = 2
) (
  input  logic             rclk,
  input  logic             arst_l,
  input  logic [NDEST-1:0] pcx_spc_grant_pa,
  input  logic [NDEST-1:0] spc_pcx_req_pq,
  input  logic             spc_pcx_atom_pq,
  input  logic             spc_quiesce_req,
  output logic [NDEST-1:0] pcx_credit_avail,
  output logic [NDEST-1:0] pcx_atom_avail,
  output logic             spc_quiesce_ack,
  output logic [2:0]       pcx_credit_err,
  output logic [1:0]       o_dbg_state
);

  typedef enum logic [1:0] {ST_RUN = 2'd0, ST_DRAIN = 2'd1, ST_QUIET = 2'd2} state_t;

  localparam logic [2:0] LP_MAX = 3'(QDEPTH);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [1:0]       r_cnt     [NDEST];
  logic [1:0]       w_cnt_nxt [NDEST];
  logic [2:0]       w_inc     [NDEST];
  logic [2:0]       w_up      [NDEST];
  logic [2:0]       w_net     [NDEST];
  logic [NDEST-1:0] w_ovf;
  logic [NDEST-1:0] w_udf;
  logic             w_multi;
  logic             w_all_zero;
  logic [2:0]       r_err;
  logic             r_ack;

  // A multi-hot request vector is dropped entirely; grants still apply.
  assign w_multi = |(spc_pcx_req_pq & (spc_pcx_req_pq - 1'b1));

  always_comb begin
    w_ovf      = '0;
    w_udf      = '0;
    w_all_zero = 1'b1;
    for (int i = 0; i < NDEST; i++) begin
      w_inc[i] = 3'd0;
      if (!w_multi && spc_pcx_req_pq[i])
        w_inc[i] = spc_pcx_atom_pq ? 3'd2 : 3'd1;
      w_up[i]      = {1'b0, r_cnt[i]} + w_inc[i];
      w_net[i]     = w_up[i] - {2'b00, pcx_spc_grant_pa[i]};
      w_cnt_nxt[i] = w_net[i][1:0];
      if (pcx_spc_grant_pa[i] && (w_up[i] == 3'd0)) begin
        w_udf[i]     = 1'b1;
        w_cnt_nxt[i] = 2'd0;
      end else if (w_net[i] > LP_MAX) begin
        w_ovf[i]     = 1'b1;
        w_cnt_nxt[i] = LP_MAX[1:0];
      end
      if (w_cnt_nxt[i] != 2'd0)
        w_all_zero = 1'b0;
    end
  end

  // Drain/quiet decisions look at the counts being written this edge.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN:   if (spc_quiesce_req) w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (!spc_quiesce_req) w_state_nxt = ST_RUN;
                else if (w_all_zero) w_state_nxt = ST_QUIET;
      ST_QUIET: if (!spc_quiesce_req) w_state_nxt = ST_RUN;
                else if (!w_all_zero) w_state_nxt = ST_DRAIN;
      default:  w_state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) begin
      r_state <= ST_RUN;
      r_err   <= 3'b000;
      r_ack   <= 1'b0;
      for (int i = 0; i < NDEST; i++) r_cnt[i] <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      r_err   <= r_err | {w_multi, |w_udf, |w_ovf};
      r_ack   <= (w_state_nxt == ST_QUIET);
      for (int i = 0; i < NDEST; i++) r_cnt[i] <= w_cnt_nxt[i];
    end
  end

  always_comb begin
    for (int i = 0; i < NDEST; i++) begin
      pcx_credit_avail[i] = (r_state == ST_RUN) && (r_cnt[i] < LP_MAX[1:0]);
      pcx_atom_avail[i]   = (r_state == ST_RUN) && (r_cnt[i] == 2'd0);
    end
  end

  assign spc_quiesce_ack = r_ack;
  assign pcx_credit_err  = r_err;
  assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_pcx_spc_credit_ctl.sv
// Bench for pcx_spc_credit_ctl: directed scenarios plus random traffic,
// compared every cycle against an arithmetic credit/quiesce model.
module tb_pcx_spc_credit_ctl;

  logic       rclk;
  logic       arst_l;
  logic [4:0] grant;
  logic [4:0] req;
  logic       atom;
  logic       qreq;
  logic [4:0] credit_avail;
  logic [4:0] atom_avail;
  logic       qack;
  logic [2:0] err;
  logic [1:0] dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  localparam int M_RUN = 0, M_DRAIN = 1, M_QUIET = 2;
  int       m_cnt [5];
  int       m_mode;
  bit [2:0] m_err;
  logic [13:0] exp_q[$];

  pcx_spc_credit_ctl #(.NDEST(5), .QDEPTH(2)) dut (
    .rclk             (rclk),
    .arst_l           (arst_l),
    .pcx_spc_grant_pa (grant),
    .spc_pcx_req_pq   (req),
    .spc_pcx_atom_pq  (atom),
    .spc_quiesce_req  (qreq),
    .pcx_credit_avail (credit_avail),
    .pcx_atom_avail   (atom_avail),
    .spc_quiesce_ack  (qack),
    .pcx_credit_err   (err),
    .o_dbg_state      (dbg_state)
  );

  // clock / reset
  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 5; i++) m_cnt[i] = 0;
    m_mode = M_RUN;
    m_err  = 3'b000;
  endfunction

  function automatic logic [13:0] model_expect();
    logic [4:0] av, aa;
    for (int i = 0; i < 5; i++) begin
      av[i] = (m_mode == M_RUN) && (m_cnt[i] < 2);
      aa[i] = (m_mode == M_RUN) && (m_cnt[i] == 0);
    end
    return {m_err, (m_mode == M_QUIET), aa, av};
  endfunction

  function automatic void model_edge(input logic [4:0] r, input logic [4:0] g,
                                     input logic a, input logic q);
    bit multi = ($countones(r) > 1);
    bit all_zero = 1;
    if (multi) m_err[2] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      int v = m_cnt[i] + ((!multi && r[i]) ? (a ? 2 : 1) : 0) - int'(g[i]);
      if (v > 2) begin v = 2; m_err[0] = 1'b1; end
      if (v < 0) begin v = 0; m_err[1] = 1'b1; end
      m_cnt[i] = v;
      if (v != 0) all_zero = 0;
    end
    case (m_mode)
      M_RUN:   if (q) m_mode = M_DRAIN;
      M_DRAIN: if (!q) m_mode = M_RUN; else if (all_zero) m_mode = M_QUIET;
      default: if (!q) m_mode = M_RUN; else if (!all_zero) m_mode = M_DRAIN;
    endcase
    exp_q.push_back(model_expect());
  endfunction

  task automatic compare_outputs();
    logic [13:0] e;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 32'd0, 32'd1);
      return;
    end
    e = exp_q.pop_front();
    check("credit_avail", credit_avail, e[4:0]);
    check("atom_avail", atom_avail, e[9:5]);
    check("quiesce_ack", qack, e[10]);
    check("credit_err", err, e[13:11]);
  endtask

  // driver: inputs change at negedge, model advances at posedge, sample #1 later
  task automatic step(input logic [4:0] r, input logic [4:0] g, input logic a, input logic q);
    @(negedge rclk);
    req = r; grant = g; atom = a; qreq = q;
    @(posedge rclk);
    model_edge(r, g, a, q);
    #1;
    compare_outputs();
  endtask

  task automatic apply_reset();
    @(negedge rclk);
    req = '0; grant = '0; atom = 1'b0; qreq = 1'b0;
    arst_l = 1'b0;
    #1;
    check("rst_avail", credit_avail, 32'h1f);
    check("rst_atom", atom_avail, 32'h1f);
    check("rst_ack", qack, 32'd0);
    check("rst_err", err, 32'd0);
    model_reset();
    exp_q.delete();
    @(negedge rclk);
    arst_l = 1'b1;
  endtask

  initial begin
    logic [4:0] r, g;
    logic a, q;
    int sel;

    arst_l = 1'b0; req = '0; grant = '0; atom = 1'b0; qreq = 1'b0;
    model_reset();
    #2;
    check("rst0_avail", credit_avail, 32'h1f);
    check("rst0_atom", atom_avail, 32'h1f);
    check("rst0_err", err, 32'd0);
    check("rst0_ack", qack, 32'd0);
    @(negedge rclk);
    arst_l = 1'b1;

    // request fill and grant return
    step(5'b00001, 5'b00000, 1'b0, 1'b0);
    step(5'b00001, 5'b00000, 1'b0, 1'b0);
    check("fill_avail", credit_avail, 32'h1e);
    step(5'b00000, 5'b00001, 1'b0, 1'b0);
    check("fill_return", credit_avail, 32'h1f);

    // atomic fill takes two grants to clear
    step(5'b00100, 5'b00000, 1'b1, 1'b0);
    check("atom_credit2", credit_avail[2], 32'd0);
    check("atom_atom2", atom_avail[2], 32'd0);
    step(5'b00000, 5'b00100, 1'b0, 1'b0);
    step(5'b00000, 5'b00100, 1'b0, 1'b0);
    check("atom_back_credit", credit_avail[2], 32'd1);
    check("atom_back_atom", atom_avail[2], 32'd1);

    // simultaneous request+grant holds, then grant-at-zero underflow
    step(5'b01000, 5'b00000, 1'b0, 1'b0);
    step(5'b01000, 5'b01000, 1'b0, 1'b0);
    check("simul_atom3", atom_avail[3], 32'd0);
    check("simul_credit3", credit_avail[3], 32'd1);
    check("simul_noerr", err, 32'd0);
    step(5'b00000, 5'b00010, 1'b0, 1'b0);
    check("underflow_err", err, 32'b010);

    // multi-hot ignored, then overflow saturates
    apply_reset();
    step(5'b00011, 5'b00000, 1'b0, 1'b0);
    check("multihot_err", err, 32'b100);
    check("multihot_avail", credit_avail, 32'h1f);
    step(5'b10000, 5'b00000, 1'b1, 1'b0);
    step(5'b10000, 5'b00000, 1'b0, 1'b0);
    check("ovf_err", err[0], 32'd1);
    step(5'b00000, 5'b10000, 1'b0, 1'b0);
    check("ovf_sat", credit_avail[4], 32'd1);

    // quiesce with counts {1,0,2,0,0}
    apply_reset();
    step(5'b00001, 5'b00000, 1'b0, 1'b0);
    step(5'b00100, 5'b00000, 1'b1, 1'b0);
    step(5'b00000, 5'b00000, 1'b0, 1'b1);
    check("q_avail", credit_avail, 32'd0);
    check("q_atom", atom_avail, 32'd0);
    step(5'b00000, 5'b00101, 1'b0, 1'b1);
    check("q_ack_early", qack, 32'd0);
    step(5'b00000, 5'b00100, 1'b0, 1'b1);
    check("q_ack", qack, 32'd1);
    step(5'b00010, 5'b00000, 1'b0, 1'b1);
    check("q_back_drain", qack, 32'd0);
    step(5'b00000, 5'b00010, 1'b0, 1'b1);
    check("q_ack_again", qack, 32'd1);
    step(5'b00000, 5'b00000, 1'b0, 1'b0);
    check("q_release_ack", qack, 32'd0);
    check("q_release_avail", credit_avail, 32'h1f);

    // reset while draining with outstanding counts, no clock edge needed
    step(5'b00001, 5'b00000, 1'b0, 1'b0);
    step(5'b00000, 5'b00000, 1'b0, 1'b1);
    check("middrain_avail0", credit_avail, 32'd0);
    @(posedge rclk);
    #2;
    arst_l = 1'b0;
    #1;
    check("middrain_avail", credit_avail, 32'h1f);
    check("middrain_atom", atom_avail, 32'h1f);
    check("middrain_ack", qack, 32'd0);
    check("middrain_err", err, 32'd0);
    model_reset();
    exp_q.delete();
    qreq = 1'b0;
    @(negedge rclk);
    arst_l = 1'b1;

    // random traffic
    q = 1'b0;
    for (int n = 0; n < 800; n++) begin
      if (n % 200 == 199) apply_reset();
      if (arst_l == 1'b1 && n % 200 == 0) q = 1'b0;
      sel = $urandom_range(0, 9);
      if (sel < 5) r = 5'(1 << sel);
      else if (sel == 8) r = 5'(1 << $urandom_range(0, 4)) | 5'(1 << $urandom_range(0, 4));
      else r = 5'b00000;
      a = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < 5; i++)
        g[i] = (m_cnt[i] > 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 29) == 0) q = !q;
      step(r, g, a, q);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL timeout: simulation did not complete");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
